sys_clk_div_ds_multi: RTL and testbench

//  Simulation-side multi-channel differential clock source for the PCIe BMD test benches.

---
 rtl/sys_clk_div_ds_multi.sv | 176 +++++++++++++++++
 tb/tb_sys_clk_div_ds_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_clk_div_ds_multi.sv
// Multi-channel differential clock source for simulation benches.
// Each channel divides sys_clk by a programmable half-period and can be started,
// stopped or re-ratioed at run time without glitches. Requests arrive through a
// valid/ready port and are held in a per-channel shadow until a safe apply point.
//
// Ports:
//   sys_clk    free-running source clock, rising edge
//   sys_rst    synchronous active-high reset
//   cfg_valid  config request valid
//   cfg_ready  request can be accepted (target channel has no pending shadow)
//   cfg_ch     target channel; values >= NUM_CH are accepted and dropped
//   cfg_half   new half-period in sys_clk cycles (0 behaves as 1)
//   cfg_en     1 = run channel, 0 = stop channel
//   clk_p      generated clocks, true polarity
//   clk_n      complement of clk_p
//   ch_active  channel running or waiting on its start stagger
module sys_clk_div_ds_multi #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CH_W         = 1,
  parameter int unsigned HALF_W       = 8,
  parameter int unsigned DEFAULT_HALF = 4,
  parameter int unsigned STAGGER      = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] clk_p,
  output logic [NUM_CH-1:0] clk_n,
  output logic [NUM_CH-1:0] ch_active
);

  typedef enum logic [1:0] {StIdle, StStart, StHigh, StLow} state_e;

  localparam int unsigned StagMax = (NUM_CH - 1) * STAGGER;
  localparam int unsigned StagW   = (StagMax < 2) ? 1 : $clog2(StagMax + 1);
  localparam logic [HALF_W-1:0] DefHalf =
      (DEFAULT_HALF == 0) ? HALF_W'(1) : HALF_W'(DEFAULT_HALF);

  logic [NUM_CH-1:0]    pend;
  logic [2**CH_W-1:0]   pend_ext;
  logic [HALF_W-1:0]    cfg_half_clamp;

  // Out-of-range channels read as "not pending", so they are always accepted.
  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_CH-1:0]   = pend;
  end

  assign cfg_ready      = ~pend_ext[cfg_ch];
  assign cfg_half_clamp = (cfg_half == '0) ? HALF_W'(1) : cfg_half;
  assign clk_n          = ~clk_p;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [StagW-1:0] StagLoad = StagW'(i * STAGGER);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] sh_half_q, sh_half_d;
    logic              sh_en_q, sh_en_d;
    logic              pend_q, pend_d;
    logic              clk_q, clk_d;
    logic [StagW-1:0]  stag_q, stag_d;
    logic              acc;

    assign acc = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      sh_half_d = sh_half_q;
      sh_en_d   = sh_en_q;
      pend_d    = pend_q;
      clk_d     = clk_q;
      stag_d    = stag_q;

      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            pend_d = 1'b0;
            half_d = sh_half_q;
            if (sh_en_q) begin
              state_d = StStart;
              stag_d  = StagLoad;
            end
          end
        end
        StStart: begin
          if (stag_q == '0) begin
            clk_d   = 1'b1;
            state_d = StHigh;
            cnt_d   = half_q - HALF_W'(1);
          end else begin
            stag_d = stag_q - StagW'(1);
          end
        end
        StHigh: begin
          if (cnt_q == '0) begin
            // Falling edge is the only point where a ratio change may land.
            clk_d = 1'b0;
            if (pend_q) begin
              pend_d = 1'b0;
              half_d = sh_half_q;
              if (!sh_en_q) begin
                state_d = StIdle;
              end else begin
                state_d = StLow;
                cnt_d   = sh_half_q - HALF_W'(1);
              end
            end else begin
              state_d = StLow;
              cnt_d   = half_q - HALF_W'(1);
            end
          end else begin
            cnt_d = cnt_q - HALF_W'(1);
          end
        end
        StLow: begin
          // Output is already low, so a stop can land immediately; a ratio
          // change waits for the next fall.
          if (pend_q && !sh_en_q) begin
            pend_d  = 1'b0;
            half_d  = sh_half_q;
            state_d = StIdle;
          end else if (cnt_q == '0) begin
            clk_d   = 1'b1;
            state_d = StHigh;
            cnt_d   = half_q - HALF_W'(1);
          end else begin
            cnt_d = cnt_q - HALF_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase

      // Acceptance implies pend_q == 0, so it never collides with an apply.
      if (acc) begin
        sh_half_d = cfg_half_clamp;
        sh_en_d   = cfg_en;
        pend_d    = 1'b1;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        half_q    <= DefHalf;
        sh_half_q <= DefHalf;
        sh_en_q   <= 1'b0;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
        stag_q    <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        half_q    <= half_d;
        sh_half_q <= sh_half_d;
        sh_en_q   <= sh_en_d;
        pend_q    <= pend_d;
        clk_q     <= clk_d;
        stag_q    <= stag_d;
      end
    end

    assign pend[i]      = pend_q;
    assign clk_p[i]     = clk_q;
    assign ch_active[i] = (state_q != StIdle);
  end

endmodule

// File: tb/tb_sys_clk_div_ds_multi.sv
module tb_sys_clk_div_ds_multi;

  int errors = 0;
  int checks = 0;

  logic       clk = 1'b0;
  logic       rst;

  // Two-channel instance with a 2-bit cfg_ch so out-of-range ids are reachable.
  logic       cfg_valid, cfg_ready, cfg_en;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [1:0] clk_p, clk_n, ch_active;

  // Four-channel staggered instance.
  logic       cfg_valid4, cfg_ready4, cfg_en4;
  logic [1:0] cfg_ch4;
  logic [7:0] cfg_half4;
  logic [3:0] clk_p4, clk_n4, ch_active4;

  always #5 clk = ~clk;

  sys_clk_div_ds_multi #(
    .NUM_CH(2), .CH_W(2), .HALF_W(8), .DEFAULT_HALF(4), .STAGGER(0)
  ) u_dut (
    .sys_clk(clk), .sys_rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_en(cfg_en),
    .clk_p(clk_p), .clk_n(clk_n), .ch_active(ch_active)
  );

  sys_clk_div_ds_multi #(
    .NUM_CH(4), .CH_W(2), .HALF_W(8), .DEFAULT_HALF(4), .STAGGER(2)
  ) u_dut4 (
    .sys_clk(clk), .sys_rst(rst), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
    .cfg_ch(cfg_ch4), .cfg_half(cfg_half4), .cfg_en(cfg_en4),
    .clk_p(clk_p4), .clk_n(clk_n4), .ch_active(ch_active4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] half, input logic en);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_half  = half;
    cfg_en    = en;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    checks++;
    if (clk_p !== 2'b00 || clk_n !== 2'b11 || ch_active !== 2'b00 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: clk_p=%b clk_n=%b act=%b rdy=%b, want 00 11 00 1",
               clk_p, clk_n, ch_active, cfg_ready);
    end
    tick(); tick();
    rst = 1'b0;
    // Get both channels running, leave a request pending, then reset mid-run.
    cfg_write(2'd0, 8'd3, 1'b1);
    cfg_write(2'd1, 8'd2, 1'b1);
    repeat (7) tick();
    checks++;
    if (ch_active !== 2'b11) begin
      errors++;
      $display("FAIL reset_prerun_active: act=%b, want 11", ch_active);
    end
    cfg_write(2'd0, 8'd9, 1'b0);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_prerun_pending: rdy=%b, want 0", cfg_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (clk_p !== 2'b00 || clk_n !== 2'b11 || ch_active !== 2'b00 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midrun: clk_p=%b clk_n=%b act=%b rdy=%b, want 00 11 00 1",
               clk_p, clk_n, ch_active, cfg_ready);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (clk_p !== 2'b00 || ch_active !== 2'b00) begin
      errors++;
      $display("FAIL reset_after_release: clk_p=%b act=%b, want 00 00", clk_p, ch_active);
    end
  endtask

  task automatic test_basic;
    logic exp;
    do_reset();
    cfg_write(2'd0, 8'd3, 1'b1);
    tick();
    checks++;
    if (ch_active[0] !== 1'b1 || clk_p[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: act0=%b clk_p0=%b, want 1 0", ch_active[0], clk_p[0]);
    end
    tick();
    for (int k = 0; k < 12; k++) begin
      exp = ((k / 3) % 2) == 0;
      checks++;
      if (clk_p[0] !== exp || clk_n !== ~clk_p) begin
        errors++;
        $display("FAIL basic_wave k=%0d: clk_p0=%b clk_n=%b, want clk_p0=%b clk_n=~clk_p",
                 k, clk_p[0], clk_n, exp);
      end
      tick();
    end
  endtask

  task automatic test_stagger;
    int rise[4];
    int fall[4];
    for (int i = 0; i < 4; i++) begin
      rise[i] = -1;
      fall[i] = -1;
    end
    for (int k = 0; k < 40; k++) begin
      if (k < 4) begin
        cfg_valid4 = 1'b1;
        cfg_ch4    = 2'(k);
        cfg_half4  = 8'd4;
        cfg_en4    = 1'b1;
      end else begin
        cfg_valid4 = 1'b0;
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (rise[i] < 0 && clk_p4[i]) rise[i] = k;
        else if (rise[i] >= 0 && fall[i] < 0 && !clk_p4[i]) fall[i] = k;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rise[i] < 0 || (rise[i] - i) - 2 !== 2 * i) begin
        errors++;
        $display("FAIL stagger_offset ch%0d: rel offset=%0d, want %0d",
                 i, (rise[i] < 0) ? -1 : (rise[i] - i) - 2, 2 * i);
      end
      checks++;
      if (fall[i] < 0 || fall[i] - rise[i] !== 4) begin
        errors++;
        $display("FAIL stagger_high ch%0d: high=%0d, want 4", i, fall[i] - rise[i]);
      end
    end
    checks++;
    if (clk_n4 !== ~clk_p4 || ch_active4 !== 4'hf) begin
      errors++;
      $display("FAIL stagger_final: clk_n4=%b clk_p4=%b act4=%b, want ~clk_p4 and 1111",
               clk_n4, clk_p4, ch_active4);
    end
  endtask

  task automatic test_ratio_change;
    logic exp;
    do_reset();
    cfg_write(2'd1, 8'd2, 1'b1);
    tick();
    tick();
    checks++;
    if (clk_p[1] !== 1'b1) begin
      errors++;
      $display("FAIL ratio_first_rise: clk_p1=%b, want 1", clk_p[1]);
    end
    cfg_write(2'd1, 8'd5, 1'b1);
    checks++;
    if (cfg_ready !== 1'b0 || clk_p[1] !== 1'b1) begin
      errors++;
      $display("FAIL ratio_accept: rdy=%b clk_p1=%b, want 0 1", cfg_ready, clk_p[1]);
    end
    for (int j = 2; j <= 13; j++) begin
      tick();
      exp = (j >= 7 && j <= 11);
      checks++;
      if (clk_p[1] !== exp) begin
        errors++;
        $display("FAIL ratio_wave j=%0d: clk_p1=%b, want %b", j, clk_p[1], exp);
      end
      if (j == 2) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL ratio_ready_after_fall: rdy=%b, want 1", cfg_ready);
        end
      end
    end
  endtask

  task automatic test_disable;
    logic exp;
    do_reset();
    cfg_write(2'd0, 8'd4, 1'b1);
    tick();
    tick();
    checks++;
    if (clk_p[0] !== 1'b1) begin
      errors++;
      $display("FAIL disable_rise: clk_p0=%b, want 1", clk_p[0]);
    end
    cfg_write(2'd0, 8'd4, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      if (j > 1) tick();
      exp = (j < 4);
      checks++;
      if (clk_p[0] !== exp || ch_active[0] !== exp) begin
        errors++;
        $display("FAIL disable_wave j=%0d: clk_p0=%b act0=%b, want %b %b",
                 j, clk_p[0], ch_active[0], exp, exp);
      end
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL disable_ready: rdy=%b, want 1", cfg_ready);
    end
  endtask

  task automatic test_half_zero;
    logic exp;
    do_reset();
    cfg_ch = 2'd3;
    cfg_write(2'd3, 8'd7, 1'b1);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready: rdy=%b, want 1", cfg_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (clk_p !== 2'b00 || ch_active !== 2'b00) begin
        errors++;
        $display("FAIL oor_quiet k=%0d: clk_p=%b act=%b, want 00 00", k, clk_p, ch_active);
      end
    end
    cfg_write(2'd0, 8'd0, 1'b1);
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      exp = (k % 2) == 0;
      checks++;
      if (clk_p[0] !== exp || ch_active[0] !== 1'b1) begin
        errors++;
        $display("FAIL half0_wave k=%0d: clk_p0=%b act0=%b, want %b 1",
                 k, clk_p[0], ch_active[0], exp);
      end
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_half   = 8'd0;
    cfg_en     = 1'b0;
    cfg_valid4 = 1'b0;
    cfg_ch4    = 2'd0;
    cfg_half4  = 8'd0;
    cfg_en4    = 1'b0;
    test_reset();
    test_basic();
    test_stagger();
    test_ratio_change();
    test_disable();
    test_half_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
